// File: rtl/msk_mod_iq.sv
// rtl/msk_mod_iq.sv - MSK baseband I/Q modulator, one bit per symbol in, SPS I/Q samples out
//
// Continuous-phase MSK: each accepted bit moves the phase by +/-pi/2 over SPS
// samples (+ for bit 1, - for bit 0). The phase is held across idle gaps so the
// waveform stays continuous. The cos/sin lookup is registered, so the first
// sample of a symbol accepted in cycle c is valid in cycle c+2.
//
// Ports:
//   clk           sample clock (FS)
//   rst_n         asynchronous active-low reset
//   s_bit_tdata   symbol bit (1: +pi/2, 0: -pi/2)
//   s_bit_tvalid  bit valid
//   s_bit_tready  bit accepted this cycle (IDLE, or last sample of a symbol)
//   I_out/Q_out   signed 16-bit samples, forced to 0 when IQ_val is low
//   IQ_val        sample valid
//   underflow     one-cycle pulse when a symbol ends with no next bit
//
// Optional feature: define MSK_MOD_DIFF_ENC_EN to differentially precode the
// bit stream (dir = bit ^ previous dir) for offset-QPSK style demodulators.

module msk_mod_iq #(
    parameter int SPS     = 8,
    parameter int PHASE_W = 10,
    parameter int AMP     = 16383
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_bit_tdata,
    input  logic               s_bit_tvalid,
    output logic               s_bit_tready,
    output logic signed [15:0] I_out,
    output logic signed [15:0] Q_out,
    output logic               IQ_val,
    output logic               underflow
);

    localparam int QN    = 2 ** (PHASE_W - 2);      // counts per quarter turn
    localparam int STEP  = QN / SPS;
    localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;

    if (PHASE_W < 3 || SPS < 2 || SPS > QN || (SPS & (SPS - 1)) != 0 ||
        AMP < 0 || AMP > 32767) begin : g_param_err
        $error("msk_mod_iq: illegal SPS/PHASE_W/AMP combination");
    end

    // sin over the first quadrant by Taylor series; the argument never exceeds
    // pi/2, where 12 terms are far below one LSB of error.
    function automatic int quarter_sin(input int i);
        real x;
        real x2;
        real term;
        real sum;
        x    = 3.14159265358979323846 * real'(i) / (2.0 * real'(QN));
        x2   = x * x;
        term = x;
        sum  = x;
        for (int k = 1; k <= 12; k++) begin
            term = -term * x2 / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        // real-to-int conversion rounds half away from zero
        return int'(real'(AMP) * sum);
    endfunction

    logic signed [15:0] tab [0:QN];

    for (genvar gi = 0; gi <= QN; gi++) begin : g_tab
        localparam int VAL = quarter_sin(gi);
        assign tab[gi] = 16'(VAL);
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [PHASE_W-1:0] ph, ph_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               dir, dir_nxt;
    logic               uf_nxt;
    logic               last;
    logic               hs;
    logic               bit_dir;

    assign last         = (cnt == CNT_W'(SPS - 1));
    assign s_bit_tready = rst_n & ((state == IDLE) | ((state == RUN) & last));
    assign hs           = s_bit_tvalid & s_bit_tready;

`ifdef MSK_MOD_DIFF_ENC_EN
    logic prev_dir_bit;

    assign bit_dir = s_bit_tdata ^ prev_dir_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_dir_bit <= 1'b0;
        end else if (hs) begin
            prev_dir_bit <= bit_dir;
        end
    end
`else
    assign bit_dir = s_bit_tdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ph    <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_nxt;
            ph    <= ph_nxt;
            cnt   <= cnt_nxt;
            dir   <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        cnt_nxt   = cnt;
        dir_nxt   = dir;
        uf_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    dir_nxt   = bit_dir;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // The last step of a symbol always completes, so the held
                // phase lands exactly on the next quarter turn.
                ph_nxt  = dir ? (ph + PHASE_W'(STEP)) : (ph - PHASE_W'(STEP));
                cnt_nxt = cnt + CNT_W'(1);
                if (last) begin
                    cnt_nxt = '0;
                    if (hs) begin
                        dir_nxt = bit_dir;
                    end else begin
                        state_nxt = IDLE;
                        uf_nxt    = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Quadrant folding: top two phase bits pick the quadrant, the rest index
    // the quarter table forwards (sin) and backwards (cos).
    logic [1:0]         quad;
    logic [PHASE_W-2:0] idx_s;
    logic [PHASE_W-2:0] idx_c;
    logic signed [15:0] sin_a, cos_a, sin_v, cos_v;

    assign quad  = ph[PHASE_W-1 -: 2];
    assign idx_s = {1'b0, ph[PHASE_W-3:0]};
    assign idx_c = (PHASE_W - 1)'(QN) - idx_s;

    always_comb begin
        sin_a = tab[idx_s];
        cos_a = tab[idx_c];
        cos_v = '0;
        sin_v = '0;
        case (quad)
            2'd0: begin cos_v =  cos_a; sin_v =  sin_a; end
            2'd1: begin cos_v = -sin_a; sin_v =  cos_a; end
            2'd2: begin cos_v = -cos_a; sin_v = -sin_a; end
            default: begin cos_v = sin_a; sin_v = -cos_a; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            I_out     <= '0;
            Q_out     <= '0;
            IQ_val    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            IQ_val    <= (state == RUN);
            I_out     <= (state == RUN) ? cos_v : '0;
            Q_out     <= (state == RUN) ? sin_v : '0;
            underflow <= uf_nxt;
        end
    end

endmodule
